// File: rtl/dc_loop_sequencer.sv
// ============================================================================
// Module   : dc_loop_sequencer
// Brief    : PID update sequencer for the BPSK DC-offset tracking loop, using
//            one time-multiplexed signed multiplier for the KP/KI/KD terms.
//            Build option DC_LOOP_SAT_EN adds an anti-windup clamp on the
//            integrator; without it the integrator wraps.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dc_loop_sequencer #(
    parameter int SYMBOL_WIDTH = 16,
    parameter int SYMBOL_FRAC  = 14,
    parameter int KP           = 1638,
    parameter int KI           = 3,
    parameter int KD           = 164
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           err_valid,
    output logic                           err_ready,
    input  logic signed [SYMBOL_WIDTH-1:0] err_in,
    output logic                           delta_valid,
    input  logic                           delta_ready,
    output logic signed [SYMBOL_WIDTH-1:0] delta_out,
    output logic                           busy
);

    localparam int W  = SYMBOL_WIDTH;
    localparam int AW = SYMBOL_WIDTH + 3;
    localparam int PW = 2 * SYMBOL_WIDTH;

    localparam logic signed [W-1:0] c_kp = W'(KP);
    localparam logic signed [W-1:0] c_ki = W'(KI);
    localparam logic signed [W-1:0] c_kd = W'(KD);

    localparam logic signed [AW:0] c_dmax = (AW+1)'((2 ** (W - 1)) - 1);
    localparam logic signed [AW:0] c_dmin = (AW+1)'(-(2 ** (W - 1)));

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_MUL_P = 3'd2,
        S_MUL_I = 3'd3,
        S_MUL_D = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic signed [W-1:0]  r_err_reg;
    logic signed [W-1:0]  r_err_prev;
    logic signed [W-1:0]  r_sum;
    logic signed [W-1:0]  r_dif;
    logic signed [AW-1:0] r_acc;

    logic signed [W-1:0]  w_mul_a;
    logic signed [W-1:0]  w_mul_b;
    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_term;
    logic signed [AW-1:0] w_acc_add;
    logic signed [AW:0]   w_fin;
    logic signed [W-1:0]  w_fin_sat;
    logic signed [W-1:0]  w_sum_next;

    assign err_ready = (r_state == S_IDLE);
    assign busy      = ~err_ready;

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (err_valid) w_state_next = S_PREP;
                S_PREP:  w_state_next = S_MUL_P;
                S_MUL_P: w_state_next = S_MUL_I;
                S_MUL_I: w_state_next = S_MUL_D;
                S_MUL_D: w_state_next = S_OUT;
                S_OUT:   if (delta_ready) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Shared multiplier: operands selected by the current phase
    // ------------------------------------------------------------------
    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (r_state)
            S_MUL_P: begin
                w_mul_a = r_err_reg;
                w_mul_b = c_kp;
            end
            S_MUL_I: begin
                w_mul_a = r_sum;
                w_mul_b = c_ki;
            end
            S_MUL_D: begin
                w_mul_a = r_dif;
                w_mul_b = c_kd;
            end
            default: begin
                w_mul_a = '0;
                w_mul_b = '0;
            end
        endcase
    end

    // Arithmetic shift floors toward minus infinity, so -1*K yields -1.
    assign w_prod    = PW'(w_mul_a) * PW'(w_mul_b);
    assign w_term    = AW'(w_prod >>> SYMBOL_FRAC);
    assign w_acc_add = r_acc + w_term;
    assign w_fin     = (AW+1)'(r_acc) + (AW+1)'(w_term);

    always_comb begin
        w_fin_sat = w_fin[W-1:0];
        if (w_fin > c_dmax) begin
            w_fin_sat = c_dmax[W-1:0];
        end else if (w_fin < c_dmin) begin
            w_fin_sat = c_dmin[W-1:0];
        end
    end

`ifdef DC_LOOP_SAT_EN
    localparam logic signed [W:0] c_smax = (W+1)'((2 ** (W - 1)) - 1);
    localparam logic signed [W:0] c_smin = (W+1)'(-(2 ** (W - 1)));

    logic signed [W:0] w_sum_wide;

    assign w_sum_wide = (W+1)'(r_sum) + (W+1)'(r_err_reg);

    always_comb begin
        w_sum_next = w_sum_wide[W-1:0];
        if (w_sum_wide > c_smax) begin
            w_sum_next = c_smax[W-1:0];
        end else if (w_sum_wide < c_smin) begin
            w_sum_next = c_smin[W-1:0];
        end
    end
`else
    assign w_sum_next = r_sum + r_err_reg;
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_reg   <= '0;
            r_err_prev  <= '0;
            r_sum       <= '0;
            r_dif       <= '0;
            r_acc       <= '0;
            delta_out   <= '0;
            delta_valid <= 1'b0;
        end else if (clear) begin
            // delta_out deliberately keeps its last value across a clear
            r_err_prev  <= '0;
            r_sum       <= '0;
            r_acc       <= '0;
            delta_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (err_valid) r_err_reg <= err_in;
                end
                S_PREP: begin
                    r_sum      <= w_sum_next;
                    r_dif      <= r_err_reg - r_err_prev;
                    r_err_prev <= r_err_reg;
                end
                S_MUL_P: r_acc <= w_term;
                S_MUL_I: r_acc <= w_acc_add;
                S_MUL_D: begin
                    delta_out   <= w_fin_sat;
                    delta_valid <= 1'b1;
                end
                S_OUT: begin
                    if (delta_ready) delta_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dc_loop_sequencer.sv
// ============================================================================
// Module   : tb_dc_loop_sequencer
// Brief    : Directed, table-driven bench for dc_loop_sequencer plus
//            hand-written backpressure, clear and async-reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dc_loop_sequencer;

`ifdef DC_LOOP_SAT_EN
    localparam int C_SECOND = 1643;
`else
    localparam int C_SECOND = 1632;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clear = 1'b0;
    logic               err_valid = 1'b0;
    logic signed [15:0] err_in = '0;
    logic               delta_ready = 1'b1;

    logic               err_ready, delta_valid, busy;
    logic signed [15:0] delta_out;
    logic               d2_err_ready, d2_delta_valid, d2_busy;
    logic signed [15:0] d2_delta_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dc_loop_sequencer dut (
        .clk(clk), .rst(rst), .clear(clear),
        .err_valid(err_valid), .err_ready(err_ready), .err_in(err_in),
        .delta_valid(delta_valid), .delta_ready(delta_ready),
        .delta_out(delta_out), .busy(busy)
    );

    dc_loop_sequencer #(.KP(32767), .KI(32767), .KD(32767)) dut_big (
        .clk(clk), .rst(rst), .clear(clear),
        .err_valid(err_valid), .err_ready(d2_err_ready), .err_in(err_in),
        .delta_valid(d2_delta_valid), .delta_ready(delta_ready),
        .delta_out(d2_delta_out), .busy(d2_busy)
    );

    typedef struct {
        bit           do_reset;
        int           err;
        int           exp_main;
        bit           chk_big;
        int           exp_big;
    } vec_t;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!err_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check({name, "_idle_timeout"}, int'(err_ready), 1);
    endtask

    task automatic accept(input int v);
        err_in    = 16'(v);
        err_valid = 1'b1;
        @(posedge clk); #1;
        err_valid = 1'b0;
    endtask

    task automatic send(input string name, input int v, input int e1,
                        input bit chk2, input int e2);
        int lat = 0;
        wait_idle(name);
        accept(v);
        while (!delta_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check({name, "_latency"}, lat, 4);
        check({name, "_delta"}, int'(delta_out), e1);
        if (chk2) check({name, "_delta_big"}, int'(d2_delta_out), e2);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b1,  16384,  1805,     1'b0, 0};
        vecs[1] = '{1'b0,  16384,  C_SECOND, 1'b0, 0};
        vecs[2] = '{1'b1,     -1,    -3,     1'b0, 0};
        vecs[3] = '{1'b0,     -1,    -2,     1'b0, 0};
        vecs[4] = '{1'b1,      0,     0,     1'b0, 0};
        vecs[5] = '{1'b0,   8192,   902,     1'b0, 0};
        vecs[6] = '{1'b0,  -8192,  -983,     1'b0, 0};
        vecs[7] = '{1'b1,  32767,  3607,     1'b1, 32767};
        vecs[8] = '{1'b1, -32768, -3610,     1'b1, -32768};

        do_reset();
        check("reset_delta_valid", int'(delta_valid), 0);
        check("reset_delta_out", int'(delta_out), 0);
        check("reset_err_ready", int'(err_ready), 1);
        check("reset_busy", int'(busy), 0);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_reset) do_reset();
            send($sformatf("vec%0d", i), vecs[i].err, vecs[i].exp_main,
                 vecs[i].chk_big, vecs[i].exp_big);
        end

        // Backpressure: result held, busy, and stray err_valid ignored
        do_reset();
        delta_ready = 1'b0;
        send("bp", 16384, 1805, 1'b0, 0);
        for (int k = 0; k < 10; k++) begin
            err_in    = 16'sd123;
            err_valid = k[0];
            @(posedge clk); #1;
            check($sformatf("bp_hold%0d_valid", k), int'(delta_valid), 1);
            check($sformatf("bp_hold%0d_delta", k), int'(delta_out), 1805);
            check($sformatf("bp_hold%0d_ready", k), int'(err_ready), 0);
        end
        err_valid   = 1'b0;
        delta_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", int'(delta_valid), 0);
        check("bp_release_ready", int'(err_ready), 1);
        check("bp_release_busy", int'(busy), 0);
        check("bp_delta_retained", int'(delta_out), 1805);
        send("bp_next", 16384, C_SECOND, 1'b0, 0);

        // Clear while in MUL_I drops the transaction and loop state
        do_reset();
        wait_idle("clr");
        accept(16384);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("clr_busy_before", int'(busy), 1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clr_err_ready", int'(err_ready), 1);
        check("clr_delta_valid", int'(delta_valid), 0);
        send("clr_next", 16384, 1805, 1'b0, 0);

        // Asynchronous reset in MUL_P takes effect without a clock edge
        wait_idle("arst");
        accept(16384);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        check("arst_delta_out", int'(delta_out), 0);
        check("arst_delta_valid", int'(delta_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_err_ready", int'(err_ready), 1);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        send("arst_next", 16384, 1805, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
